// File: rtl/mod_counter_if.sv
// Control and status bundle for one modulo-N counter stage.
// The controller side drives the controls; the counter side returns count and tc.
interface mod_counter_if #(
    parameter int WIDTH = 6
);
    logic             en;
    logic             clr;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;

    modport master (
        output en, clr, up_dn, load, load_val,
        input  count, tc
    );

    modport slave (
        input  en, clr, up_dn, load, load_val,
        output count, tc
    );
endinterface

// File: rtl/mod_counter.sv
// Synchronous modulo-N up/down counter stage with clear, clamped load and wrap/saturate.
// Latency: count updates one edge after a control; tc is combinational in the same cycle.
// Backpressure: none; tc drives the next stage's en directly so cascades step on the same edge.
module mod_counter #(
    parameter int WIDTH   = 6,
    parameter int MODULUS = 60,
    parameter int WRAP    = 1
) (
    input  logic          clk,
    input  logic          reset,
    mod_counter_if.slave  bus
);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("mod_counter: MODULUS must lie in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] TERM_HI = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] load_clamped;
    logic             at_top;
    logic             at_zero;
    logic             term;

    always_comb begin
        at_top       = (count_q == TERM_HI);
        at_zero      = (count_q == '0);
        term         = bus.up_dn ? at_top : at_zero;
        load_clamped = (bus.load_val > TERM_HI) ? TERM_HI : bus.load_val;
        count_d      = count_q;

        if (bus.clr) begin
            count_d = '0;
        end else if (bus.load) begin
            count_d = load_clamped;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                // Terminal compare before the increment; also folds a forced out-of-range value back to 0.
                if (count_q >= TERM_HI) begin
                    count_d = (at_top && WRAP == 0) ? count_q : '0;
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (at_zero) begin
                    count_d = (WRAP != 0) ? TERM_HI : count_q;
                end else if (count_q > TERM_HI) begin
                    count_d = TERM_HI;
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = bus.en & term & ~reset & ~bus.clr & ~bus.load;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: wrap and saturate stages under shared stimulus, plus a seconds/minutes cascade.
module tb_mod_counter;

    localparam int W = 6;
    localparam int M = 60;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mod_counter_if #(.WIDTH(W)) if_w ();
    mod_counter_if #(.WIDTH(W)) if_s ();
    mod_counter_if #(.WIDTH(W)) if_sec ();
    mod_counter_if #(.WIDTH(W)) if_min ();

    mod_counter #(.WIDTH(W), .MODULUS(M), .WRAP(1)) u_wrap (.clk(clk), .reset(reset), .bus(if_w.slave));
    mod_counter #(.WIDTH(W), .MODULUS(M), .WRAP(0)) u_sat  (.clk(clk), .reset(reset), .bus(if_s.slave));
    mod_counter #(.WIDTH(W), .MODULUS(M), .WRAP(1)) u_sec  (.clk(clk), .reset(reset), .bus(if_sec.slave));
    mod_counter #(.WIDTH(W), .MODULUS(M), .WRAP(1)) u_min  (.clk(clk), .reset(reset), .bus(if_min.slave));

    assign if_min.en = if_sec.tc;

    int total = 0;
    int bad   = 0;
    int mw    = 0;
    int ms    = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour in plain modular arithmetic.
    function automatic int model_next(input int c, input int m, input bit wrap, input bit r,
                                      input bit cl, input bit ld, input int lv, input bit e, input bit up);
        if (r || cl) return 0;
        if (ld) return (lv < m) ? lv : m - 1;
        if (!e) return c;
        if (up) return (c == m - 1 && !wrap) ? c : (c + 1) % m;
        return (c == 0 && !wrap) ? c : (c + m - 1) % m;
    endfunction

    function automatic int model_tc(input int c, input int m, input bit r, input bit cl,
                                    input bit ld, input bit e, input bit up);
        if (r || cl || ld || !e) return 0;
        return (up ? (c == m - 1) : (c == 0)) ? 1 : 0;
    endfunction

    task automatic step(input bit r, input bit e, input bit cl, input bit up, input bit ld, input int lv);
        @(negedge clk);
        reset       = r;
        if_w.en     = e;  if_s.en     = e;
        if_w.clr    = cl; if_s.clr    = cl;
        if_w.up_dn  = up; if_s.up_dn  = up;
        if_w.load   = ld; if_s.load   = ld;
        if_w.load_val = W'(lv);
        if_s.load_val = W'(lv);
        #1;
        chk("tc_wrap", int'(if_w.tc), model_tc(mw, M, r, cl, ld, e, up));
        chk("tc_sat",  int'(if_s.tc), model_tc(ms, M, r, cl, ld, e, up));
        mw = model_next(mw, M, 1'b1, r, cl, ld, lv, e, up);
        ms = model_next(ms, M, 1'b0, r, cl, ld, lv, e, up);
        @(posedge clk);
        #1;
        chk("cnt_wrap", int'(if_w.count), mw);
        chk("cnt_sat",  int'(if_s.count), ms);
    endtask

    initial begin
        reset = 1'b1;
        if_w.en = 1'b0; if_w.clr = 1'b0; if_w.up_dn = 1'b1; if_w.load = 1'b0; if_w.load_val = '0;
        if_s.en = 1'b0; if_s.clr = 1'b0; if_s.up_dn = 1'b1; if_s.load = 1'b0; if_s.load_val = '0;
        if_sec.en = 1'b0; if_sec.clr = 1'b0; if_sec.up_dn = 1'b1; if_sec.load = 1'b0; if_sec.load_val = '0;
        if_min.clr = 1'b0; if_min.up_dn = 1'b1; if_min.load = 1'b0; if_min.load_val = '0;

        // Reset with en high, then idle hold.
        repeat (2) step(1, 1, 0, 1, 0, 0);
        repeat (5) step(0, 0, 0, 1, 0, 0);

        // Full up run: wrap stage returns to 0, saturate stage pins at 59 with tc held.
        repeat (60) step(0, 1, 0, 1, 0, 0);
        repeat (3)  step(0, 1, 0, 1, 0, 0);

        // Down from 0: wrap goes to 59, saturate holds 0 with tc high.
        step(0, 0, 1, 1, 0, 0);
        repeat (4) step(0, 1, 0, 0, 0, 0);

        // Load, clamp, clear-over-load, load-over-enable at terminal.
        step(0, 0, 0, 1, 1, 37);
        step(0, 0, 0, 1, 1, 63);
        step(0, 0, 1, 1, 1, 20);
        step(0, 0, 0, 1, 1, 59);
        step(0, 1, 0, 1, 1, 10);

        // Reset mid-count while enabled, then resume.
        step(0, 0, 0, 1, 1, 42);
        step(1, 1, 0, 1, 0, 0);
        repeat (3) step(0, 1, 0, 1, 0, 0);

        // Random mix of all controls.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 75,
                 $urandom_range(0, 99) < 4,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) < 8,
                 int'($urandom_range(0, 63)));
        end

        // Cascade: seconds tc drives minutes en for one full hour.
        step(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3600; i++) begin
            @(negedge clk);
            reset     = 1'b0;
            if_sec.en = 1'b1;
            #1;
            chk("tc_sec", int'(if_sec.tc), ((i % 60) == 59) ? 1 : 0);
            @(posedge clk);
            #1;
            chk("cnt_sec", int'(if_sec.count), (i + 1) % 60);
            chk("cnt_min", int'(if_min.count), ((i + 1) / 60) % 60);
        end
        @(negedge clk);
        if_sec.en = 1'b0;
        chk("sec_end", int'(if_sec.count), 0);
        chk("min_end", int'(if_min.count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
